tdm_demux: RTL and testbench
============================

Name: tdm_demux

Overview:
- Receive end of the team's 2:1/N:1 multiplexed link: recovers NCH parallel channel words from a single time-division-multiplexed serial bit stream.
- A frame is NCH consecutive slots of W bits each. Slot 0 is marked by a frame_sync pulse.
- Sits after the link serializer/mux; each recovered word is delivered to its channel register with a per-channel valid pulse.

Parameters:
- NCH, 4, number of channels (slots per frame), >= 2
- W, 8, bits per slot, >= 2

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- din  input  1  serial data bit, MSB of each slot first
- din_valid  input  1  din carries a bit this cycle; bits are accepted only when high
- frame_sync  input  1  qualified by din_valid; marks the current bit as bit 0 (MSB) of slot 0
- ch_data  output  NCH*W  channel words; channel i occupies bits [i*W+W-1 : i*W]
- ch_valid  output  NCH  one-cycle pulse; bit i high means ch_data slice i was just updated
- frame_done  output  1  one-cycle pulse when slot NCH-1 completes
- sync_err  output  1  one-cycle pulse on an unexpected frame_sync (resync event)
- in_frame  output  1  high while in RECV

Behaviour:
- Reset: clk and rst_n are the only clock and reset. rst_n low forces the following asynchronously:
  - state = HUNT; bit counter and slot counter = 0; shift register = 0
  - ch_data = 0; ch_valid = 0; frame_done = 0; sync_err = 0; in_frame = 0
- Only cycles with din_valid=1 advance anything. din_valid=0 holds all counters and the shift register.
- ch_valid, frame_done and sync_err are 0 in any cycle not named below.
- FSM states: HUNT, RECV.
- HUNT:
  - Accepted bits without frame_sync are discarded; no flags.
  - Accepted bit with frame_sync: load it as shift bit 0, bit_cnt=1, slot_cnt=0, go to RECV.
- RECV:
  - Each accepted bit shifts in: shift = {shift[W-2:0], din}; bit_cnt increments.
  - On the W-th bit of a slot (bit_cnt == W-1 when the bit is accepted):
    - next cycle, ch_data slice slot_cnt = completed word and ch_valid[slot_cnt] = 1
    - bit_cnt returns to 0; slot_cnt increments
  - Latency: exactly 1 clk from acceptance of the slot's last bit to the ch_valid pulse and ch_data update.
  - Other ch_data slices hold their values.
  - On the last bit of slot NCH-1: frame_done pulses in the same cycle as ch_valid[NCH-1]; state returns to HUNT; slot_cnt wraps to 0.
  - Back-to-back frames: the next frame's first bit must carry frame_sync. It may arrive the cycle immediately after the last bit; HUNT then handles it, with no lost bit and no bubble required.
- Unexpected frame_sync in RECV (any accepted bit other than one arriving while in HUNT):
  - sync_err pulses the next cycle.
  - The partial slot is discarded; no ch_valid for it.
  - The bit is taken as slot 0 bit 0: bit_cnt=1, slot_cnt=0, state remains RECV.
  - Slices already updated this frame keep their new values.
- frame_sync with din_valid=0 is ignored.
- in_frame = (state == RECV), registered.
- Reset asserted mid-frame: all state clears immediately; the partial frame is lost; no pulses are produced on reset release.
- Widths: bit_cnt is $clog2(W) bits; slot_cnt is $clog2(NCH) bits; counters compare to W-1 and NCH-1, so non-power-of-2 values must work.

Test Plan:
- Reset: hold rst_n=0, drive random din/din_valid/frame_sync -> all outputs 0 and in_frame=0 throughout.
- Nominal frame, NCH=4, W=8, din_valid=1 continuous, frame_sync on the first bit, words 0xA5, 0x3C, 0xFF, 0x01 sent MSB first ->
  - ch_valid = 0001, 0010, 0100, 1000 one cycle after bits 8, 16, 24, 32
  - frame_done with ch_valid[3]
  - ch_data = 0x01FF3CA5
  - in_frame drops after the frame
- Gapped input: same frame with din_valid toggling 1,0,1,0 -> identical ch_data; each ch_valid 1 cycle after its slot's last valid bit; no pulse during gaps.
- Hunt discard: 5 valid bits without frame_sync, then the nominal frame -> the 5 bits are ignored and the result equals the nominal test.
- Resync: frame_sync reasserted at bit 3 of slot 1 ->
  - sync_err pulse
  - no ch_valid[1] for the aborted slot
  - ch_data slice 0 keeps its value from the aborted frame
  - the new frame 0x11, 0x22, 0x33, 0x44 is recovered correctly
- Back-to-back and reset mid-frame:
  - two frames with the second's frame_sync the cycle after the first's last bit -> two frame_done pulses 32 cycles apart
  - rst_n pulse at slot 2 -> ch_data=0, no further ch_valid until a new frame_sync

Source files
------------

// File: rtl/tdm_demux.sv
// TDM link receiver: hunts for frame_sync, then deserializes NCH slots of W bits
// (MSB first) into per-channel registers, with one-cycle valid/done/error pulses.
module tdm_demux_ch #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld,
    input  logic [W-1:0] word,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (ld) q <= word;
    end
endmodule

module tdm_demux #(
    parameter int NCH = 4,
    parameter int W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [NCH*W-1:0] ch_data,
    output logic [NCH-1:0]   ch_valid,
    output logic             frame_done,
    output logic             sync_err,
    output logic             in_frame
);
    localparam int BW = $clog2(W);
    localparam int SW = $clog2(NCH);

    typedef enum logic {HUNT, RECV} state_t;

    state_t         state, state_nxt;
    logic [BW-1:0]  bit_cnt, bit_nxt;
    logic [SW-1:0]  slot_cnt, slot_nxt;
    logic [W-1:0]   shift, shift_nxt;
    logic [W-1:0]   word;
    logic           word_done, frame_end, resync;
    logic [NCH-1:0] ld;
    logic [NCH-1:0][W-1:0] ch_q;

    assign word = {shift[W-2:0], din};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= HUNT;
            bit_cnt  <= '0;
            slot_cnt <= '0;
            shift    <= '0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_nxt;
            slot_cnt <= slot_nxt;
            shift    <= shift_nxt;
        end
    end

    // Any accepted frame_sync restarts slot 0; in RECV that is also a resync.
    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        slot_nxt  = slot_cnt;
        shift_nxt = shift;
        if (din_valid) begin
            if (frame_sync) begin
                state_nxt = RECV;
                bit_nxt   = BW'(1);
                slot_nxt  = '0;
                shift_nxt = {{(W-1){1'b0}}, din};
            end else if (state == RECV) begin
                shift_nxt = word;
                if (bit_cnt == BW'(W-1)) begin
                    bit_nxt = '0;
                    if (slot_cnt == SW'(NCH-1)) begin
                        slot_nxt  = '0;
                        state_nxt = HUNT;
                    end else begin
                        slot_nxt = slot_cnt + SW'(1);
                    end
                end else begin
                    bit_nxt = bit_cnt + BW'(1);
                end
            end
        end
    end

    always_comb begin
        resync    = (state == RECV) && din_valid && frame_sync;
        word_done = (state == RECV) && din_valid && !frame_sync && (bit_cnt == BW'(W-1));
        frame_end = word_done && (slot_cnt == SW'(NCH-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_valid   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            in_frame   <= 1'b0;
        end else begin
            ch_valid   <= ld;
            frame_done <= frame_end;
            sync_err   <= resync;
            in_frame   <= (state_nxt == RECV);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ld[i] = word_done && (slot_cnt == SW'(i));
        tdm_demux_ch #(.W(W)) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .ld    (ld[i]),
            .word  (word),
            .q     (ch_q[i])
        );
        assign ch_data[i*W +: W] = ch_q[i];
    end
endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: table of whole-frame vectors plus hand-written
// resync, back-to-back and reset-mid-frame sequences.
module tb_tdm_demux;
    localparam int NCH = 4;
    localparam int W   = 8;
    localparam int FW  = NCH * W;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           din = 1'b0, din_valid = 1'b0, frame_sync = 1'b0;
    logic [FW-1:0]  ch_data;
    logic [NCH-1:0] ch_valid;
    logic           frame_done, sync_err, in_frame;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int fd_cyc[$];

    typedef struct {
        string         name;
        int            junk;
        bit            gap;
        logic [FW-1:0] words;
        logic [FW-1:0] exp_data;
    } vec_t;
    vec_t vecs[4];

    always #5 clk = ~clk;

    tdm_demux #(.NCH(NCH), .W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .frame_done (frame_done),
        .sync_err   (sync_err),
        .in_frame   (in_frame)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, then check the pulses/in_frame that the accepted bit produces.
    task automatic bit_cyc(input logic dv, input logic d, input logic fs,
                           input logic [NCH-1:0] ev, input logic efd, input logic ese,
                           input logic eif, input string tag);
        din_valid  = dv;
        din        = d;
        frame_sync = fs;
        @(posedge clk);
        #1;
        cyc++;
        if (frame_done === 1'b1) fd_cyc.push_back(cyc);
        chk({tag, " ch_valid"},   64'(ch_valid),   64'(ev));
        chk({tag, " frame_done"}, 64'(frame_done), 64'(efd));
        chk({tag, " sync_err"},   64'(sync_err),   64'(ese));
        chk({tag, " in_frame"},   64'(in_frame),   64'(eif));
    endtask

    task automatic send_slot(input logic [W-1:0] w, input int s, input int from,
                             input bit serr, input bit gap, input string tag);
        logic           last, fd, eif;
        logic [NCH-1:0] ev;
        for (int b = from; b < W; b++) begin
            last = (b == W-1);
            ev   = last ? (NCH'(1) << s) : '0;
            fd   = last && (s == NCH-1);
            eif  = !fd;
            bit_cyc(1'b1, w[W-1-b], (s == 0 && b == 0), ev, fd,
                    serr && (s == 0) && (b == 0), eif, tag);
            if (gap) bit_cyc(1'b0, 1'($urandom), 1'($urandom), '0, 1'b0, 1'b0, eif, {tag, " gap"});
        end
    endtask

    task automatic send_frame(input logic [FW-1:0] words, input bit gap, input string tag);
        for (int s = 0; s < NCH; s++)
            send_slot(words[s*W +: W], s, 0, 1'b0, gap, tag);
    endtask

    initial begin
        vecs[0] = '{name: "nominal",    junk: 0, gap: 1'b0, words: 32'h01FF3CA5, exp_data: 32'h01FF3CA5};
        vecs[1] = '{name: "gapped",     junk: 0, gap: 1'b1, words: 32'h01FF3CA5, exp_data: 32'h01FF3CA5};
        vecs[2] = '{name: "hunt5",      junk: 5, gap: 1'b0, words: 32'h01FF3CA5, exp_data: 32'h01FF3CA5};
        vecs[3] = '{name: "mixed",      junk: 3, gap: 1'b1, words: 32'hC3007E80, exp_data: 32'hC3007E80};

        // Reset held with random activity: everything stays zero.
        for (int i = 0; i < 8; i++) begin
            bit_cyc(1'($urandom), 1'($urandom), 1'($urandom), '0, 1'b0, 1'b0, 1'b0, "reset");
            chk("reset ch_data", 64'(ch_data), 64'h0);
        end
        rst_n = 1'b1;
        bit_cyc(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, "idle");

        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < vecs[v].junk; j++)
                bit_cyc(1'b1, 1'($urandom), 1'b0, '0, 1'b0, 1'b0, 1'b0, {vecs[v].name, " junk"});
            send_frame(vecs[v].words, vecs[v].gap, vecs[v].name);
            chk({vecs[v].name, " ch_data"}, 64'(ch_data), 64'(vecs[v].exp_data));
        end

        // Resync at bit 3 of slot 1.
        send_slot(8'h77, 0, 0, 1'b0, 1'b0, "resync s0");
        for (int b = 0; b < 3; b++)
            bit_cyc(1'b1, b[0], 1'b0, '0, 1'b0, 1'b0, 1'b1, "resync partial");
        bit_cyc(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b1, "resync hit");
        chk("resync slice0 kept", 64'(ch_data[7:0]), 64'h77);
        chk("resync slice1 kept", 64'(ch_data[15:8]), 64'h7E);
        send_slot(8'h11, 0, 1, 1'b0, 1'b0, "resync new s0");
        send_slot(8'h22, 1, 0, 1'b0, 1'b0, "resync new s1");
        send_slot(8'h33, 2, 0, 1'b0, 1'b0, "resync new s2");
        send_slot(8'h44, 3, 0, 1'b0, 1'b0, "resync new s3");
        chk("resync ch_data", 64'(ch_data), 64'h44332211);

        // Back-to-back frames, no bubble.
        fd_cyc.delete();
        send_frame(32'hDEADBEEF, 1'b0, "b2b f1");
        send_frame(32'h01234567, 1'b0, "b2b f2");
        chk("b2b frame_done count", 64'(fd_cyc.size()), 64'd2);
        if (fd_cyc.size() == 2) chk("b2b frame_done spacing", 64'(fd_cyc[1] - fd_cyc[0]), 64'(FW));
        chk("b2b ch_data", 64'(ch_data), 64'h01234567);

        // Reset in the middle of slot 2.
        send_slot(8'hAB, 0, 0, 1'b0, 1'b0, "midrst s0");
        send_slot(8'hCD, 1, 0, 1'b0, 1'b0, "midrst s1");
        for (int b = 0; b < 3; b++)
            bit_cyc(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, "midrst s2");
        rst_n = 1'b0;
        #2;
        chk("midrst async ch_data", 64'(ch_data), 64'h0);
        chk("midrst async in_frame", 64'(in_frame), 64'h0);
        bit_cyc(1'b1, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, "midrst held");
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++)
            bit_cyc(1'b1, 1'($urandom), 1'b0, '0, 1'b0, 1'b0, 1'b0, "midrst nosync");
        chk("midrst ch_data after release", 64'(ch_data), 64'h0);
        send_frame(32'h01FF3CA5, 1'b0, "midrst recover");
        chk("midrst recover ch_data", 64'(ch_data), 64'h01FF3CA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
